fetch_unit: RTL and testbench

//  Instruction fetch stage feeding decode/register-file stage of risc_processor.

---
 rtl/fetch_unit.sv | 153 +++++++++++++++
 tb/tb_fetch_unit.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Purpose: instruction fetch stage; one outstanding imem request, {pc, inst} buffered in a small FIFO for decode.
// Latency: request issued 1 cycle after IDLE with a free slot; pushed on response; one instruction per 3 cycles with 1-cycle memory.
// Backpressure: requests issue only while a FIFO slot is free; decode pops with inst_valid/inst_ready. Optional macro FETCH_PERF_CNT_EN adds perf counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;
  logic [31:0]   fifo_pc   [FIFO_DEPTH];
  logic [31:0]   fifo_inst [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          accept, push, pop;

  assign imem_req_addr = fetch_pc;
  assign inst_valid    = (count != '0);
  assign inst_data     = fifo_inst[rd_ptr];
  assign inst_pc       = fifo_pc[rd_ptr];
  // A redirect flushes the buffer, so a simultaneous pop must not move the read pointer.
  assign pop           = inst_valid & inst_ready & ~redirect_valid;

  // Next-state and request handshake; redirect overrides normal progress.
  always_comb begin
    state_nxt      = state;
    imem_req_valid = 1'b0;
    accept         = 1'b0;
    push           = 1'b0;
    case (state)
      IDLE: begin
        // Only start a request when a slot is guaranteed for its response.
        if (!redirect_valid && count < CW'(FIFO_DEPTH)) state_nxt = REQ;
      end
      REQ: begin
        imem_req_valid = 1'b1;
        accept         = imem_req_ready;
        if (redirect_valid)      state_nxt = imem_req_ready ? DRAIN : IDLE;
        else if (imem_req_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          state_nxt = IDLE;
          push      = ~redirect_valid;
        end else if (redirect_valid) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // Swallow the response of a request that was accepted before the redirect.
        if (imem_rsp_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Fetch PC advances on accept, reloads word-aligned on redirect; req_pc tags the in-flight request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
    end else begin
      if (accept) req_pc <= fetch_pc;
      if (redirect_valid) fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
      else if (accept)    fetch_pc <= fetch_pc + 32'd4;
    end
  end

  // FIFO pointers and occupancy; redirect empties the buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; cleared at reset so the head reads zero before the first push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc[i]   <= '0;
        fifo_inst[i] <= '0;
      end
    end else if (push) begin
      fifo_pc[wr_ptr]   <= req_pc;
      fifo_inst[wr_ptr] <= imem_rsp_data;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic discard;
  assign discard = imem_rsp_valid &
                   ((state == DRAIN) | ((state == WAIT) & redirect_valid));

  // Counts pushed instructions and every instruction thrown away (buffered or in flight).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (push) perf_fetched <= perf_fetched + 32'd1;
      perf_flushed <= perf_flushed
                      + (redirect_valid ? 32'(count) : 32'd0)
                      + (discard ? 32'd1 : 32'd0);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Purpose: self-checking bench for fetch_unit with a variable-latency memory model.
// Latency: memory responds lat cycles after accept (lat >= 1).
// Backpressure: req_ready and inst_ready driven directly by the stimulus.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready = 1'b0;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
`endif

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (req_valid),
    .imem_req_addr  (req_addr),
    .imem_req_ready (req_ready),
    .imem_rsp_valid (rsp_valid),
    .imem_rsp_data  (rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_flushed   (perf_flushed)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Memory model: accept seen at negedge, response (data = ~addr) lat cycles later.
  int          lat = 1;
  int          cnt = 0;
  logic        acc = 1'b0;
  logic [31:0] acc_addr = 32'h0;
  logic [31:0] hold_addr = 32'h0;
  logic [31:0] acc_log [$];

  always @(negedge clk) begin
    acc      = rst && req_valid && req_ready;
    acc_addr = req_addr;
    if (acc) acc_log.push_back(req_addr);
  end

  always @(posedge clk) begin
    #1;
    rsp_valid = 1'b0;
    if (acc) begin
      cnt       = lat;
      hold_addr = acc_addr;
    end
    if (cnt > 0) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        rsp_valid = 1'b1;
        rsp_data  = ~hold_addr;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b0;
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
    req_ready      = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    acc_log.delete();
    rst = 1'b1;
  endtask

  typedef struct {
    logic        ready;
    logic        inst_rdy;
    logic        exp_rv;
    logic [31:0] exp_addr;
    logic        exp_iv;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tv [9];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int found;
    int hi;

    // Streaming with always-ready memory and decode: one instruction every 3 cycles.
    tv[0] = '{1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0};
    tv[1] = '{1'b1, 1'b1, 1'b0, 32'h4, 1'b0, 32'h0};
    tv[2] = '{1'b1, 1'b1, 1'b0, 32'h4, 1'b1, 32'h0};
    tv[3] = '{1'b1, 1'b1, 1'b1, 32'h4, 1'b0, 32'h0};
    tv[4] = '{1'b1, 1'b1, 1'b0, 32'h8, 1'b0, 32'h0};
    tv[5] = '{1'b1, 1'b1, 1'b0, 32'h8, 1'b1, 32'h4};
    tv[6] = '{1'b1, 1'b1, 1'b1, 32'h8, 1'b0, 32'h0};
    tv[7] = '{1'b1, 1'b1, 1'b0, 32'hC, 1'b0, 32'h0};
    tv[8] = '{1'b1, 1'b1, 1'b0, 32'hC, 1'b1, 32'h8};

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", 32'(req_valid), 32'h0);
    chk("rst_req_addr", req_addr, 32'h0);
    chk("rst_inst_valid", 32'(inst_valid), 32'h0);
    chk("rst_inst_data", inst_data, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_perf_fetched", perf_fetched, 32'h0);
    chk("rst_perf_flushed", perf_flushed, 32'h0);
`endif

    // Table-driven streaming.
    do_reset();
    lat = 1; req_ready = 1'b1; inst_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      req_ready  = tv[i].ready;
      inst_ready = tv[i].inst_rdy;
      @(negedge clk);
      chk($sformatf("stream_rv[%0d]", i), 32'(req_valid), 32'(tv[i].exp_rv));
      chk($sformatf("stream_addr[%0d]", i), req_addr, tv[i].exp_addr);
      chk($sformatf("stream_iv[%0d]", i), 32'(inst_valid), 32'(tv[i].exp_iv));
      if (tv[i].exp_iv) begin
        chk($sformatf("stream_pc[%0d]", i), inst_pc, tv[i].exp_pc);
        chk($sformatf("stream_data[%0d]", i), inst_data, ~tv[i].exp_pc);
      end
    end

    // Decode stalled: exactly FIFO_DEPTH requests, then one pop frees a slot.
    do_reset();
    lat = 1; req_ready = 1'b1; inst_ready = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("full_req_count", 32'(acc_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < acc_log.size(); i++)
      chk($sformatf("full_req_addr[%0d]", i), acc_log[i], 32'(4 * i));
    chk("full_req_valid", 32'(req_valid), 32'h0);
    chk("full_inst_valid", 32'(inst_valid), 32'h1);
    chk("full_head_pc", inst_pc, 32'h0);
    chk("full_head_data", inst_data, 32'hFFFF_FFFF);
    tick();
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      @(negedge clk);
      if (req_valid) found = 1;
    end
    chk("pop_req_seen", 32'(found), 32'h1);
    chk("pop_req_addr", req_addr, 32'h10);
    chk("pop_head_pc", inst_pc, 32'h4);

    // Redirect while waiting on a slow response: drain it, refetch at target.
    do_reset();
    lat = 1; req_ready = 1'b1; inst_ready = 1'b0;
    tick();            // REQ 0x0
    tick();            // WAIT
    tick();            // IDLE, 0x0 buffered
    lat = 3;
    tick();            // REQ 0x4
    tick();            // WAIT, slow response pending
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    @(negedge clk);
    chk("redir_wait_iv_before", 32'(inst_valid), 32'h1);
    chk("redir_wait_rv_before", 32'(req_valid), 32'h0);
    tick();            // DRAIN
    redirect_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    chk("redir_wait_iv_after", 32'(inst_valid), 32'h0);
    chk("redir_drain_rv", 32'(req_valid), 32'h0);
    chk("redir_drain_addr", req_addr, 32'h100);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      if (inst_valid) found = 1;
    end
    chk("redir_new_inst_seen", 32'(found), 32'h1);
    chk("redir_new_inst_pc", inst_pc, 32'h100);
    chk("redir_new_inst_data", inst_data, ~32'h100);
    chk("redir_req_count", 32'(acc_log.size()), 32'd3);
    if (acc_log.size() >= 3) chk("redir_req_addr", acc_log[2], 32'h100);

    // Redirect in REQ without ready: request withdrawn, new aligned address.
    do_reset();
    lat = 1; req_ready = 1'b0; inst_ready = 1'b0;
    tick();            // REQ 0x0
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    @(negedge clk);
    chk("wdraw_rv_before", 32'(req_valid), 32'h1);
    chk("wdraw_addr_before", req_addr, 32'h0);
    tick();
    redirect_valid = 1'b0;
    req_ready      = 1'b1;
    @(negedge clk);
    chk("wdraw_rv_after", 32'(req_valid), 32'h0);
    chk("wdraw_addr_after", req_addr, 32'h200);
    tick();
    @(negedge clk);
    chk("wdraw_rv_again", 32'(req_valid), 32'h1);
    chk("wdraw_addr_again", req_addr, 32'h200);

    // Memory not ready for 5 cycles: request held stable, accepted on the 6th.
    do_reset();
    lat = 1; req_ready = 1'b0; inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      chk($sformatf("hold_rv[%0d]", i), 32'(req_valid), 32'h1);
      chk($sformatf("hold_addr[%0d]", i), req_addr, 32'h0);
    end
    chk("hold_no_accept", 32'(acc_log.size()), 32'd0);
    tick();
    req_ready = 1'b1;
    @(negedge clk);
    chk("hold_rv6", 32'(req_valid), 32'h1);
    tick();
    @(negedge clk);
    chk("hold_rv_after", 32'(req_valid), 32'h0);
    chk("hold_addr_after", req_addr, 32'h4);
    chk("hold_accept_count", 32'(acc_log.size()), 32'd1);

    // Reset mid-transaction: late response after release must be ignored.
    do_reset();
    lat = 3; req_ready = 1'b1; inst_ready = 1'b0;
    tick();            // REQ 0x0, accepted
    tick();            // WAIT
    rst       = 1'b0;
    req_ready = 1'b0;
    #2;
    rst = 1'b1;
    hi = 0;
    repeat (6) begin
      @(negedge clk);
      if (inst_valid) hi++;
    end
    chk("midrst_no_push", 32'(hi), 32'h0);
    chk("midrst_addr", req_addr, 32'h0);
    chk("midrst_rv", 32'(req_valid), 32'h1);

`ifdef FETCH_PERF_CNT_EN
    // Fill the buffer, then redirect: every buffered entry counts as flushed.
    do_reset();
    lat = 1; req_ready = 1'b1; inst_ready = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("perf_fetched_full", perf_fetched, 32'd4);
    chk("perf_flushed_full", perf_flushed, 32'd0);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("perf_fetched_redir", perf_fetched, 32'd4);
    chk("perf_flushed_redir", perf_flushed, 32'd4);
    chk("perf_iv_redir", 32'(inst_valid), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
